// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, opcodes and FSM state type for the register-file access controller
package reg_file_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/reg_file_access_ctrl_if.sv
// rtl/reg_file_access_ctrl_if.sv - instruction handshake, register-file port set and status signals
interface reg_file_access_ctrl_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);

  logic [31:0]       INSTR;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [ADDR_W-1:0] READREG1;
  logic [ADDR_W-1:0] READREG2;
  logic [DATA_W-1:0] REGOUT1;
  logic [DATA_W-1:0] REGOUT2;
  logic [ADDR_W-1:0] WRITEREG;
  logic [DATA_W-1:0] WRITEDATA;
  logic              WRITEENABLE;
  logic [DATA_W-1:0] RESULT;
  logic              DONE;
  logic              ERR;

  // master is the controller; slave is the fetch stage plus register file side
  modport master (
    input  INSTR, INSTR_VALID, REGOUT1, REGOUT2,
    output INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA,
           WRITEENABLE, RESULT, DONE, ERR
  );

  modport slave (
    output INSTR, INSTR_VALID, REGOUT1, REGOUT2,
    input  INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA,
           WRITEENABLE, RESULT, DONE, ERR
  );

endinterface

// File: rtl/reg_alu_op.sv
// rtl/reg_alu_op.sv - combinational opcode/operand to result mapping, arithmetic wraps modulo 2^DATA_W
module reg_alu_op
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_LOADI: result = DATA_W'(imm);
      OP_MOV:   result = opb;
      OP_ADD:   result = opa + opb;
      OP_SUB:   result = opa - opb;
      OP_AND:   result = opa & opb;
      OP_OR:    result = opa | opb;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_access_ctrl.sv
// rtl/reg_file_access_ctrl.sv - accepts one instruction, reads operands, computes and writes back the result
module reg_file_access_ctrl
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = reg_file_pkg::DATA_W,
  parameter int ADDR_W    = reg_file_pkg::ADDR_W,
  parameter int READ_WAIT = 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  reg_file_access_ctrl_if.master bus
);

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [7:0]        op_q;
  logic [7:0]        imm_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] alu_result;

  logic              ready_q;
  logic [ADDR_W-1:0] readreg1_q;
  logic [ADDR_W-1:0] readreg2_q;
  logic [ADDR_W-1:0] writereg_q;
  logic [DATA_W-1:0] writedata_q;
  logic              we_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic              err_q;

  logic [7:0] instr_op;
  logic       unused_instr_bits;

  assign instr_op          = bus.INSTR[31:24];
  assign unused_instr_bits = ^{bus.INSTR[23:19], bus.INSTR[15:11]};

  reg_alu_op #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .opa    (opa_q),
    .opb    (opb_q),
    .imm    (imm_q),
    .result (alu_result)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      dest_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ready_q     <= 1'b0;
      readreg1_q  <= '0;
      readreg2_q  <= '0;
      writereg_q  <= '0;
      writedata_q <= '0;
      we_q        <= 1'b0;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.INSTR_VALID && ready_q) begin
            op_q   <= instr_op;
            imm_q  <= bus.INSTR[7:0];
            dest_q <= bus.INSTR[16 +: ADDR_W];
            if (!is_legal_op(instr_op)) begin
              err_q <= 1'b1;
            end else if (instr_op == OP_LOADI) begin
              ready_q <= 1'b0;
              state   <= S_EXEC;
            end else begin
              // Addresses are registered on acceptance so they are on the port throughout READ.
              ready_q    <= 1'b0;
              readreg1_q <= bus.INSTR[8 +: ADDR_W];
              readreg2_q <= bus.INSTR[0 +: ADDR_W];
              state      <= S_READ;
            end
          end
        end
        S_READ: begin
          wait_cnt <= CNT_W'(READ_WAIT - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            opa_q <= bus.REGOUT1;
            opb_q <= bus.REGOUT2;
            state <= S_EXEC;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_EXEC: begin
          // Write strobe and result are registered here so they are visible for the whole WRITE cycle.
          we_q        <= 1'b1;
          done_q      <= 1'b1;
          writereg_q  <= dest_q;
          writedata_q <= alu_result;
          result_q    <= alu_result;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.INSTR_READY = ready_q;
  assign bus.READREG1    = readreg1_q;
  assign bus.READREG2    = readreg2_q;
  assign bus.WRITEREG    = writereg_q;
  assign bus.WRITEDATA   = writedata_q;
  assign bus.WRITEENABLE = we_q;
  assign bus.RESULT      = result_q;
  assign bus.DONE        = done_q;
  assign bus.ERR         = err_q;

endmodule
